// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory round-robin arbiter.
// No logic here: state encoding, command layout, owner ID and default widths.
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    // 0 = core data port (m0), 1 = harness loader/probe port (m1)
    typedef logic owner_t;

    typedef struct packed {
        logic                      we;
        logic [DATA_W_DEF/8-1:0]   be;
        logic [ADDR_W_DEF-1:0]     addr;
        logic [DATA_W_DEF-1:0]     wdata;
    } dmem_cmd_t;

    function automatic logic [1:0] owner_onehot(input owner_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a registered last-served pointer.
// Latency: grant is combinational from req; pointer moves on the edge of an accept.
// Backpressure: pointer only advances when the accept strobe is high.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Reset value 1 means "m1 was served last", so m0 wins the first tie.
    logic last_m1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_m1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_m1 <= 1'b1;
        end else if (accept && (|grant)) begin
            last_m1 <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter/sequencer for one data-memory port, one transaction in flight (option: DMEM_ARB_TIMEOUT_EN).
// Latency: zero-wait read gives gnt at cycle 0, mem_req at 1, m_rvalid at 2; write returns to IDLE at 2.
// Backpressure: gnt only in IDLE; ISSUE holds mem_req until mem_gnt; no accept while a transaction is outstanding.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              m_req_i,
    input  logic [1:0]              m_we_i,
    input  logic [2*(DATA_W/8)-1:0] m_be_i,
    input  logic [2*ADDR_W-1:0]     m_addr_i,
    input  logic [2*DATA_W-1:0]     m_wdata_i,
    output logic [1:0]              m_gnt_o,
    output logic [1:0]              m_rvalid_o,
    output logic [DATA_W-1:0]       m_rdata_o,
    output logic [1:0]              m_err_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_W/8-1:0]     mem_be_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_err_i
);

    localparam int BE_W = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state;
    cmd_t              cmd_q;
    cmd_t              win_cmd;
    owner_t            owner_q;
    owner_t            win;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [1:0]        pick;
    logic              accept;

    // Gated by rst_ni so a requester holding req during reset never sees gnt.
    assign accept = (state == IDLE) && rst_ni && (|m_req_i);
    assign win    = pick[1];

    rr_arb2 u_rr_arb2 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (m_req_i),
        .accept (accept),
        .grant  (pick)
    );

    always_comb begin
        win_cmd = '0;
        if (win) begin
            win_cmd.we    = m_we_i[1];
            win_cmd.be    = m_be_i[2*BE_W-1:BE_W];
            win_cmd.addr  = m_addr_i[2*ADDR_W-1:ADDR_W];
            win_cmd.wdata = m_wdata_i[2*DATA_W-1:DATA_W];
        end else begin
            win_cmd.we    = m_we_i[0];
            win_cmd.be    = m_be_i[BE_W-1:0];
            win_cmd.addr  = m_addr_i[ADDR_W-1:0];
            win_cmd.wdata = m_wdata_i[DATA_W-1:0];
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_hit;

    // Counter sits at 0 on the first ISSUE cycle, so mem_req is held exactly TIMEOUT cycles.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT[0];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cmd_q   <= '0;
            owner_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q   <= win_cmd;
                        owner_q <= win;
                        state   <= ISSUE;
`ifdef DMEM_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_gnt_i) begin
                        if (cmd_q.we) begin
                            state <= IDLE;
                        end else if (mem_rvalid_i) begin
                            rdata_q <= mem_rdata_i;
                            err_q   <= mem_err_i;
                            state   <= RESP;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                WAIT_R: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        err_q   <= mem_err_i;
                        state   <= RESP;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m_gnt_o     = accept ? pick : 2'b00;
    assign m_rvalid_o  = (state == RESP) ? owner_onehot(owner_q) : 2'b00;
    assign m_err_o     = ((state == RESP) && err_q) ? owner_onehot(owner_q) : 2'b00;
    assign m_rdata_o   = rdata_q;

    assign mem_req_o   = (state == ISSUE);
    assign mem_we_o    = cmd_q.we;
    assign mem_be_o    = cmd_q.be;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter; memory responses are driven cycle by cycle from each task.
module tb_dmem_rr_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  m_req_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_addr_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_gnt_o;
    logic [1:0]  m_rvalid_o;
    logic [31:0] m_rdata_o;
    logic [1:0]  m_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int tests_run;
    int tests_failed;

    dmem_rr_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m_req_i      (m_req_i),
        .m_we_i       (m_we_i),
        .m_be_i       (m_be_i),
        .m_addr_i     (m_addr_i),
        .m_wdata_i    (m_wdata_i),
        .m_gnt_o      (m_gnt_o),
        .m_rvalid_o   (m_rvalid_o),
        .m_rdata_o    (m_rdata_o),
        .m_err_o      (m_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m_req_i = 2'b00;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m_req_i = 2'b00; m_we_i = 2'b00; m_be_i = 8'h00; m_addr_i = '0; m_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        step();
        step();
        tests_run++;
        if ({m_gnt_o, m_rvalid_o, m_err_o, mem_req_o} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got gnt=%b rvalid=%b err=%b mem_req=%b want all 0", m_gnt_o, m_rvalid_o, m_err_o, mem_req_o);
        end
        tests_run++;
        if ({m_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o} !== 101'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%b we=%b want 0", m_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o);
        end
        rst_ni = 1'b1;
    endtask

    // m0 read with a zero-wait memory.
    task automatic test_read_zero_wait();
        m_req_i = 2'b01; m_we_i = 2'b00; m_addr_i[31:0] = 32'h100;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; mem_err_i = 1'b0;
        #1;
        tests_run++;
        if (m_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL rd_gnt_c0: got %b want 01", m_gnt_o); end
        step();
        m_req_i = 2'b00;
        #1;
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
            tests_failed++; $display("FAIL rd_mem_c1: got req=%b addr=%h we=%b want 1 100 0", mem_req_o, mem_addr_o, mem_we_o);
        end
        step();
        tests_run++;
        if (m_rvalid_o !== 2'b01 || m_rdata_o !== 32'hDEADBEEF || m_err_o !== 2'b00) begin
            tests_failed++; $display("FAIL rd_resp_c2: got rvalid=%b data=%h err=%b want 01 deadbeef 00", m_rvalid_o, m_rdata_o, m_err_o);
        end
        step();
        tests_run++;
        if (m_rvalid_o !== 2'b00 || mem_req_o !== 1'b0 || m_rdata_o !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL rd_after_c3: got rvalid=%b mem_req=%b data=%h want 00 0 deadbeef", m_rvalid_o, mem_req_o, m_rdata_o);
        end
    endtask

    // Both requesters read continuously from reset; grants must alternate.
    task automatic test_alternate();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        do_reset();
        m_we_i = 2'b00;
        m_addr_i = {32'h2000, 32'h1000};
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_err_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (i % 2 == 0) ? 32'h1000 : 32'h2000;
            m_req_i = 2'b11;
            mem_rdata_i = 32'hA000_0000 + i;
            #1;
            tests_run++;
            if (m_gnt_o !== exp_gnt) begin tests_failed++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, m_gnt_o, exp_gnt); end
            step();
            tests_run++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr || m_gnt_o !== 2'b00) begin
                tests_failed++; $display("FAIL alt_issue[%0d]: got req=%b addr=%h gnt=%b want 1 %h 00", i, mem_req_o, mem_addr_o, m_gnt_o, exp_addr);
            end
            step();
            tests_run++;
            if (m_rvalid_o !== exp_gnt || m_rdata_o !== 32'hA000_0000 + i) begin
                tests_failed++; $display("FAIL alt_resp[%0d]: got rvalid=%b data=%h want %b %h", i, m_rvalid_o, m_rdata_o, exp_gnt, 32'hA000_0000 + i);
            end
            step();
        end
        m_req_i = 2'b00;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

    // m1 write passes through untouched, then an m0 write with be = 0.
    task automatic test_write();
        m_req_i = 2'b10; m_we_i = 2'b10; m_be_i = 8'b0110_0000;
        m_addr_i[63:32] = 32'h20; m_wdata_i[63:32] = 32'h11223344;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        #1;
        tests_run++;
        if (m_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL wr_gnt_c0: got %b want 10", m_gnt_o); end
        step();
        m_req_i = 2'b00;
        #1;
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0110 || mem_addr_o !== 32'h20 || mem_wdata_o !== 32'h11223344) begin
            tests_failed++; $display("FAIL wr_mem_c1: got req=%b we=%b be=%b addr=%h wdata=%h want 1 1 0110 20 11223344",
                                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        tests_run++;
        if (m_rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL wr_rvalid_c1: got %b want 00", m_rvalid_o); end
        step();
        m_req_i = 2'b01; m_we_i = 2'b01; m_be_i[3:0] = 4'b0000; m_addr_i[31:0] = 32'h24; m_wdata_i[31:0] = 32'h55AA55AA;
        #1;
        tests_run++;
        if (mem_req_o !== 1'b0 || m_rvalid_o !== 2'b00 || m_gnt_o !== 2'b01) begin
            tests_failed++; $display("FAIL wr_idle_c2: got mem_req=%b rvalid=%b gnt=%b want 0 00 01", mem_req_o, m_rvalid_o, m_gnt_o);
        end
        step();
        m_req_i = 2'b00;
        #1;
        tests_run++;
        if (mem_be_o !== 4'b0000 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h24 || mem_req_o !== 1'b1) begin
            tests_failed++; $display("FAIL wr_be0: got be=%b we=%b addr=%h req=%b want 0000 1 24 1", mem_be_o, mem_we_o, mem_addr_o, mem_req_o);
        end
        step();
        tests_run++;
        if (m_rvalid_o !== 2'b00 || mem_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL wr_be0_done: got rvalid=%b mem_req=%b want 00 0", m_rvalid_o, mem_req_o);
        end
        m_we_i = 2'b00; mem_gnt_i = 1'b0;
    endtask

    // gnt after 3 wait cycles, rvalid 2 cycles later; m1 waits and is accepted right after RESP.
    task automatic test_slow_memory();
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        logic [1:0] exp_err;
        logic       exp_req;
        int         m0_rv_count;
        m0_rv_count = 0;
        m_req_i = 2'b01; m_we_i = 2'b00; m_addr_i = {32'h80, 32'h40};
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        #1;
        tests_run++;
        if (m_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL slow_gnt_c0: got %b want 01", m_gnt_o); end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            step();
            m_req_i      = {(cyc <= 8) ? 1'b1 : 1'b0, 1'b0};
            mem_gnt_i    = (cyc == 4) || (cyc == 9);
            mem_rvalid_i = (cyc == 6) || (cyc == 9);
            mem_err_i    = (cyc == 9);
            mem_rdata_i  = (cyc == 9) ? 32'hBEEF0002 : 32'hCAFE0001;
            #1;
            exp_gnt = (cyc == 8) ? 2'b10 : 2'b00;
            exp_req = (cyc <= 4) || (cyc == 9);
            exp_rv  = (cyc == 7) ? 2'b01 : (cyc == 10) ? 2'b10 : 2'b00;
            exp_err = (cyc == 10) ? 2'b10 : 2'b00;
            if (m_rvalid_o[0]) m0_rv_count++;
            tests_run++;
            if (m_gnt_o !== exp_gnt || mem_req_o !== exp_req || m_rvalid_o !== exp_rv || m_err_o !== exp_err) begin
                tests_failed++; $display("FAIL slow_c%0d: got gnt=%b req=%b rvalid=%b err=%b want %b %b %b %b",
                                         cyc, m_gnt_o, mem_req_o, m_rvalid_o, m_err_o, exp_gnt, exp_req, exp_rv, exp_err);
            end
            if (cyc <= 4) begin
                tests_run++;
                if (mem_addr_o !== 32'h40) begin tests_failed++; $display("FAIL slow_addr_c%0d: got %h want 40", cyc, mem_addr_o); end
            end
            if (cyc == 7 || cyc == 8) begin
                tests_run++;
                if (m_rdata_o !== 32'hCAFE0001) begin tests_failed++; $display("FAIL slow_rdata_c%0d: got %h want cafe0001", cyc, m_rdata_o); end
            end
        end
        tests_run++;
        if (m0_rv_count != 1) begin tests_failed++; $display("FAIL slow_rv_once: got %0d m0 responses want 1", m0_rv_count); end
        tests_run++;
        if (m_rdata_o !== 32'hBEEF0002) begin tests_failed++; $display("FAIL slow_m1_data: got %h want beef0002", m_rdata_o); end
        step();
        m_req_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask

    // Reset pulse while a read waits for data; the late rvalid must vanish and the pointer restart at m0.
    task automatic test_reset_in_wait();
        m_req_i = 2'b01; m_we_i = 2'b00; m_addr_i[31:0] = 32'h300;
        #1;
        tests_run++;
        if (m_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL rst_gnt_c0: got %b want 01", m_gnt_o); end
        step();
        m_req_i = 2'b00; mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        #1;
        tests_run++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h300) begin
            tests_failed++; $display("FAIL rst_wait_r: got req=%b addr=%h want 0 300", mem_req_o, mem_addr_o);
        end
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (mem_addr_o !== 32'h0 || m_rdata_o !== 32'h0 || m_rvalid_o !== 2'b00 || m_gnt_o !== 2'b00 || mem_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async: got addr=%h rdata=%h rvalid=%b gnt=%b req=%b want all 0",
                                     mem_addr_o, m_rdata_o, m_rvalid_o, m_gnt_o, mem_req_o);
        end
        step();
        step();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (m_rvalid_o !== 2'b00 || m_rdata_o !== 32'h0) begin
                tests_failed++; $display("FAIL rst_late_rv[%0d]: got rvalid=%b rdata=%h want 00 0", k, m_rvalid_o, m_rdata_o);
            end
            step();
        end
        mem_rvalid_i = 1'b0;
        m_req_i = 2'b11;
        #1;
        tests_run++;
        if (m_gnt_o !== 2'b01) begin tests_failed++; $display("FAIL rst_tie: got %b want 01", m_gnt_o); end
        step();
        m_req_i = 2'b00; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        step();
        tests_run++;
        if (m_rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL rst_tie_resp: got %b want 01", m_rvalid_o); end
        step();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    endtask

`ifdef DMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m_req_i = 2'b10; m_we_i = 2'b00; m_addr_i[63:32] = 32'h500;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h12345678;
        #1;
        tests_run++;
        if (m_gnt_o !== 2'b10) begin tests_failed++; $display("FAIL tmo_gnt: got %b want 10", m_gnt_o); end
        for (int cyc = 1; cyc <= 17; cyc++) begin
            step();
            m_req_i = 2'b00;
            #1;
            tests_run++;
            if (mem_req_o !== (cyc <= 16)) begin tests_failed++; $display("FAIL tmo_req_c%0d: got %b want %b", cyc, mem_req_o, cyc <= 16); end
        end
        tests_run++;
        if (m_rvalid_o !== 2'b10 || m_err_o !== 2'b10 || m_rdata_o !== 32'h0) begin
            tests_failed++; $display("FAIL tmo_resp: got rvalid=%b err=%b rdata=%h want 10 10 0", m_rvalid_o, m_err_o, m_rdata_o);
        end
        step();
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read_zero_wait();
        test_alternate();
        test_write();
        test_slow_memory();
        test_reset_in_wait();
`ifdef DMEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of a single data-memory port that uses the req/gnt/rvalid/rdata/err bus.
- Port m0 is the core's data port; port m1 is the harness loader/probe port.
- Holds one transaction in flight at a time and latches the winning command.
- Returns read data to the owning requester only.
- Sits between the core and the data-memory model in the verification top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 16, cycles before an outstanding memory access is aborted (only used with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- m_req_i  in  [1:0]  request per requester.
- m_we_i  in  [1:0]  write enable per requester.
- m_be_i  in  2x[DATA_W/8]  byte enables.
- m_addr_i  in  2x[ADDR_W]  address.
- m_wdata_i  in  2x[DATA_W]  write data.
- m_gnt_o  out  [1:0]  command accepted (one-hot).
- m_rvalid_o  out  [1:0]  read response valid (one-hot).
- m_rdata_o  out  [DATA_W]  read data, shared, qualified by m_rvalid_o.
- m_err_o  out  [1:0]  error, qualified by m_rvalid_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  [DATA_W/8]  memory byte enables.
- mem_addr_o  out  [ADDR_W]  memory address.
- mem_wdata_o  out  [DATA_W]  memory write data.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory read valid; may arrive in the same cycle as mem_gnt_i.
- mem_rdata_i  in  [DATA_W]  memory read data.
- mem_err_i  in  1  memory error.

Behaviour:
- Reset (async, any state):
  - FSM returns to IDLE.
  - All outputs go to 0.
  - Latched command clears.
  - Priority pointer is set to m0.
  - An in-flight transaction is dropped; no response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT_R, RESP.
- IDLE:
  - If any m_req_i is high, pick the winner and assert m_gnt_o[winner] combinationally.
  - On the clock edge, latch the winner's we/be/addr/wdata and the owner ID, then go to ISSUE.
  - A requester holds req and its command stable until it sees gnt.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not served last wins.
  - After reset: m0 wins the first tie.
  - The pointer updates only on an accept.
- ISSUE:
  - mem_req_o = 1 and mem_* driven from the latch; stays in ISSUE until mem_gnt_i.
  - On mem_gnt_i with a write: go to IDLE. No response to the requester; the write is complete at gnt.
  - On mem_gnt_i with a read and mem_rvalid_i in the same cycle: capture rdata/err, go to RESP.
  - On mem_gnt_i with a read and no rvalid: go to WAIT_R.
- WAIT_R:
  - mem_req_o = 0.
  - On mem_rvalid_i: capture rdata/err, go to RESP.
- RESP:
  - For exactly one cycle: m_rvalid_o[owner] = 1, m_rdata_o = captured data, m_err_o[owner] = captured err.
  - Then go to IDLE.
  - Outside RESP, m_rdata_o holds its last value and m_rvalid_o = 0.
- Latency:
  - Read with a zero-wait memory (gnt and rvalid in the same cycle): gnt at cycle 0, mem_req at cycle 1, m_rvalid at cycle 2.
  - Write: gnt at cycle 0, mem_req at cycle 1, back in IDLE at cycle 2.
- Throughput: no accept while a transaction is outstanding; IDLE is the only state that issues gnt.
- A request arriving in RESP is accepted the cycle after RESP.
- Byte enables pass through unchanged. A be of 0 is forwarded as-is and not special-cased.
- mem_rvalid_i outside ISSUE/WAIT_R is ignored.
- mem_err_i is only captured together with rvalid.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_R.
  - When it reaches TIMEOUT, drop mem_req_o and go to RESP with err = 1 and rdata = 0.
  - This applies to writes too: the owner then sees rvalid + err.
- Undefined: no counter is generated; the arbiter waits indefinitely.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_R, RESP).
  - struct dmem_cmd_t {we, be, addr, wdata}.
  - owner ID type.
  - default widths.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], accept strobe.
  - Output: one-hot grant.
  - Holds a registered last-served pointer; async active-low reset to m0 priority.

Test Plan:
- m0 read at addr 0x100, memory returns 0xDEADBEEF with gnt+rvalid at the same cycle -> m_gnt_o = 01 at cycle 0; mem_req_o at cycle 1 with addr 0x100; m_rvalid_o = 01 with data 0xDEADBEEF at cycle 2; m1 sees no rvalid.
- m0 and m1 request continuously from reset, all reads -> grants alternate m0, m1, m0, m1 and each response goes to the granted owner.
- m1 write, be = 4'b0110, addr 0x20, wdata 0x11223344 -> mem_* carries exactly those values for one cycle; no m_rvalid_o; back in IDLE the next cycle.
- Memory delays gnt 3 cycles and rvalid 2 further cycles -> mem_req_o is held 4 cycles with stable addr; rvalid returns to the owner once; no second gnt during the wait.
- rst_ni pulsed low while in WAIT_R -> all outputs immediately 0; the late mem_rvalid_i is ignored; the next tie grants m0.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT = 16, memory never grants -> mem_req_o drops after 16 cycles and the owner gets rvalid = 1, err = 1, rdata = 0.
